// File: rtl/instruction_fetch_pkg.sv
// Shared MiniALU definitions: widths, instruction field positions, opcodes and
// the fetch FSM state encoding.
package instruction_fetch_pkg;

   localparam int unsigned ADDR_WIDTH = 16;
   localparam int unsigned INSN_WIDTH = 28;
   localparam int unsigned TGT_WIDTH  = 8;

   localparam int unsigned OPC_MSB = 27;
   localparam int unsigned OPC_LSB = 24;
   localparam int unsigned TGT_MSB = 23;
   localparam int unsigned TGT_LSB = 16;
   localparam int unsigned SR1_MSB = 15;
   localparam int unsigned SR1_LSB = 8;
   localparam int unsigned SR0_MSB = 7;
   localparam int unsigned SR0_LSB = 0;

   typedef enum logic [3:0] {
      NOP = 4'h0,
      ADD = 4'h1,
      SUB = 4'h2,
      AND = 4'h3,
      OR  = 4'h4,
      XOR = 4'h5,
      MOV = 4'h6,
      LDI = 4'h7,
      BLE = 4'h8,
      BEQ = 4'h9,
      JMP = 4'hA
   } opcode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } fetch_state_e;

   localparam logic [INSN_WIDTH-1:0] NOP_WORD = {NOP, {(INSN_WIDTH-4){1'b0}}};

   // Branch/jump targets are 8-bit and always zero-extended to a full PC.
   function automatic logic [ADDR_WIDTH-1:0] zext_target(input logic [TGT_WIDTH-1:0] t);
      return {{(ADDR_WIDTH-TGT_WIDTH){1'b0}}, t};
   endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: control from execute, combinational ROM port and the
// instruction register outputs toward execute.
interface instruction_fetch_if;
   import instruction_fetch_pkg::*;

   logic                  iEnable;
   logic                  iStall;
   logic                  iBranchTaken;
   logic [TGT_WIDTH-1:0]  iBranchTarget;
   logic [INSN_WIDTH-1:0] iInstruction;
   logic [ADDR_WIDTH-1:0] oAddress;
   logic [INSN_WIDTH-1:0] oInstruction;
   logic                  oValid;
   logic [ADDR_WIDTH-1:0] oPC;

   modport master (
      input  iEnable, iStall, iBranchTaken, iBranchTarget, iInstruction,
      output oAddress, oInstruction, oValid, oPC
   );

   modport slave (
      output iEnable, iStall, iBranchTaken, iBranchTarget, iInstruction,
      input  oAddress, oInstruction, oValid, oPC
   );

endinterface

// File: rtl/instruction_fetch.sv
// MiniALU fetch stage: PC, instruction register and a two-state start gate.
// Resolves JMP locally and accepts taken-branch redirects from execute.
module instruction_fetch
   import instruction_fetch_pkg::*;
(
   input  logic                Clock,
   input  logic                Reset,
   instruction_fetch_if.master bus
);

   fetch_state_e          state, state_nx;
   logic [ADDR_WIDTH-1:0] pc, pc_nx;
   logic [INSN_WIDTH-1:0] ir, ir_nx;
   logic                  valid, valid_nx;
   logic [ADDR_WIDTH-1:0] opc, opc_nx;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= ST_IDLE;
         pc    <= '0;
         ir    <= NOP_WORD;
         valid <= 1'b0;
         opc   <= '0;
      end else begin
         state <= state_nx;
         pc    <= pc_nx;
         ir    <= ir_nx;
         valid <= valid_nx;
         opc   <= opc_nx;
      end
   end

   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      ir_nx    = ir;
      valid_nx = valid;
      opc_nx   = opc;
      case (state)
         ST_IDLE: begin
            if (bus.iEnable) state_nx = ST_RUN;
         end
         ST_RUN: begin
            // Branch beats stall: the wrong-path slot must be flushed regardless.
            if (bus.iBranchTaken) begin
               pc_nx    = zext_target(bus.iBranchTarget);
               ir_nx    = NOP_WORD;
               valid_nx = 1'b0;
            end else if (bus.iStall) begin
               // hold everything
            end else if (bus.iInstruction[OPC_MSB:OPC_LSB] == JMP) begin
               pc_nx    = zext_target(bus.iInstruction[TGT_MSB:TGT_LSB]);
               ir_nx    = NOP_WORD;
               valid_nx = 1'b0;
            end else begin
               ir_nx    = bus.iInstruction;
               opc_nx   = pc;
               valid_nx = 1'b1;
               pc_nx    = pc + ADDR_WIDTH'(1);
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign bus.oAddress     = pc;
   assign bus.oInstruction = ir;
   assign bus.oValid       = valid;
   assign bus.oPC          = opc;

endmodule
